// File: rtl/uart7n_tx_arbiter.sv
// Round-robin arbiter and sequencer sharing one uart7n transmitter between
// several valid/ready character sources; a grant spans a whole message.
module uart7n_tx_arbiter #(
  parameter int unsigned p_num_req        = 4,
  parameter int unsigned p_data_w         = 7,
  parameter int unsigned p_timeout_cycles = 1_000_000
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic [p_num_req-1:0]            req_valid_i,
  input  logic [p_num_req*p_data_w-1:0]   req_data_i,
  input  logic [p_num_req-1:0]            req_last_i,
  output logic [p_num_req-1:0]            req_ready_o,
  output logic [p_num_req-1:0]            grant_o,
  output logic [p_data_w-1:0]             uart_tx_data_o,
  output logic                            uart_tx_start_o,
  input  logic                            uart_tx_busy_i,
  input  logic                            uart_tx_sent_i,
  output logic                            busy_o,
  output logic                            timeout_o
);

  // state  | meaning
  // IDLE   | no owner; arbitrate when any source is valid and UART is free
  // ISSUE  | owner may hand over one character (ready asserted here only)
  // WAIT   | character in flight; start pulse in the first cycle
  // HOLD   | between characters of a message; grant retained
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

  localparam int unsigned IdxW   = (p_num_req > 1) ? $clog2(p_num_req) : 1;
  localparam int unsigned WdW    = $clog2(p_timeout_cycles);
  localparam logic [WdW-1:0] WdLoad = WdW'(p_timeout_cycles - 1);
  localparam logic [IdxW-1:0] OwnerRst = IdxW'(p_num_req - 1);

  state_t                 state_q, state_d;
  logic [p_num_req-1:0]   grant_q, grant_d;
  logic [IdxW-1:0]        owner_q, owner_d;
  logic [IdxW-1:0]        cur_q, cur_d;
  logic [p_data_w-1:0]    data_q, data_d;
  logic                   start_q, start_d;
  logic                   last_q, last_d;
  logic [WdW-1:0]         wd_q, wd_d;
  logic                   timeout_q, timeout_d;

  logic                   sel_valid;
  logic                   sel_last;
  logic [p_data_w-1:0]    sel_data;
  logic                   win_found;
  logic [IdxW-1:0]        win_idx;
  logic [p_num_req-1:0]   win_onehot;
  logic                   wd_expired;
  logic                   handshake;

  always_comb begin
    sel_valid = |(req_valid_i & grant_q);
    sel_last  = |(req_last_i & grant_q);
    sel_data  = '0;
    for (int k = 0; k < int'(p_num_req); k++) begin
      if (grant_q[k]) sel_data = req_data_i[k*p_data_w +: p_data_w];
    end
  end

  // Search begins one past the last owner so every source gets its turn.
  always_comb begin
    win_found  = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    for (int i = 1; i <= int'(p_num_req); i++) begin
      for (int k = 0; k < int'(p_num_req); k++) begin
        if (!win_found && req_valid_i[k] &&
            ((int'(owner_q) + i) % int'(p_num_req)) == k) begin
          win_found     = 1'b1;
          win_idx       = IdxW'(k);
          win_onehot[k] = 1'b1;
        end
      end
    end
  end

  assign wd_expired = (wd_q == '0);
  assign handshake  = sel_valid && !uart_tx_busy_i;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    cur_d       = cur_q;
    data_d      = data_q;
    start_d     = 1'b0;
    last_d      = last_q;
    wd_d        = wd_q;
    timeout_d   = 1'b0;
    req_ready_o = '0;

    case (state_q)
      S_IDLE: begin
        if (win_found && !uart_tx_busy_i) begin
          grant_d = win_onehot;
          cur_d   = win_idx;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!uart_tx_busy_i) req_ready_o = req_valid_i & grant_q;
        if (handshake) begin
          data_d  = sel_data;
          last_d  = sel_last;
          start_d = 1'b1;
          wd_d    = WdLoad;
          state_d = S_WAIT;
        end else if (!sel_valid) begin
          state_d = S_HOLD;
        end
      end
      S_WAIT: begin
        if (uart_tx_sent_i) begin
          if (last_q) begin
            owner_d = cur_q;
            grant_d = '0;
            state_d = S_IDLE;
          end else begin
            wd_d    = WdLoad;
            state_d = S_HOLD;
          end
        end else if (wd_expired) begin
          timeout_d = 1'b1;
          owner_d   = cur_q;
          grant_d   = '0;
          state_d   = S_IDLE;
        end else begin
          wd_d = wd_q - 1'b1;
        end
      end
      S_HOLD: begin
        if (wd_expired) begin
          timeout_d = 1'b1;
          owner_d   = cur_q;
          grant_d   = '0;
          state_d   = S_IDLE;
        end else begin
          wd_d = wd_q - 1'b1;
          if (handshake) state_d = S_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      owner_q   <= OwnerRst;
      cur_q     <= '0;
      data_q    <= '0;
      start_q   <= 1'b0;
      last_q    <= 1'b0;
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      cur_q     <= cur_d;
      data_q    <= data_d;
      start_q   <= start_d;
      last_q    <= last_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant_o         = grant_q;
  assign uart_tx_data_o  = data_q;
  assign uart_tx_start_o = start_q;
  assign busy_o          = (state_q != S_IDLE);
  assign timeout_o       = timeout_q;

endmodule
